// File: rtl/alu_share_if.sv
`default_nettype none
// ============================================================================
// alu_share_if : requester/ALU/response bundle around the shared-ALU arbiter
// Rev 1.0
// ============================================================================
interface alu_share_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*DATA_W-1:0] req_a;
  logic [2*DATA_W-1:0] req_b;
  logic [2*CTRL_W-1:0] req_op;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [CTRL_W-1:0]   alu_ctrl;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_zero;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [DATA_W-1:0]   rsp_result;
  logic                rsp_zero;
  logic                rsp_err;
  logic                busy;

  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_result, alu_zero, rsp_ready,
    output req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_result, rsp_zero,
           rsp_err, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_op, alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_result, rsp_zero,
           rsp_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// alu_share_arbiter : round-robin sharing of one combinational ALU by two requesters
// Rev 1.0
// ============================================================================
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_share_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                sel;
  logic                grant;
  logic                last_grant;
  logic                legal_op;
  logic [1:0]          req_ready_c;
  logic [1:0]          rsp_valid_c;
  logic [DATA_W-1:0]   alu_a_r;
  logic [DATA_W-1:0]   alu_b_r;
  logic [CTRL_W-1:0]   alu_ctrl_r;
  logic [DATA_W-1:0]   rsp_result_r;
  logic                rsp_zero_r;
  logic                rsp_err_r;

  // Contention goes to whoever was not served last.
  always_comb begin
    sel = 1'b0;
    case (bus.req_valid)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last_grant;
      default: sel = 1'b0;
    endcase
  end

  always_comb begin
    legal_op = alu_ctrl_r inside {CTRL_W'(4'b0010), CTRL_W'(4'b0110), CTRL_W'(4'b0000),
                                  CTRL_W'(4'b0001), CTRL_W'(4'b1100), CTRL_W'(4'b0111)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    req_ready_c = 2'b00;
    rsp_valid_c = 2'b00;
    case (state)
      IDLE: begin
        if (rst_n && (|bus.req_valid)) begin
          req_ready_c = sel ? 2'b10 : 2'b01;
          state_nxt   = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid_c = grant ? 2'b10 : 2'b01;
        if (bus.rsp_ready[grant]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      alu_a_r      <= '0;
      alu_b_r      <= '0;
      alu_ctrl_r   <= '0;
      rsp_result_r <= '0;
      rsp_zero_r   <= 1'b0;
      rsp_err_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            grant      <= sel;
            alu_a_r    <= sel ? bus.req_a[2*DATA_W-1:DATA_W] : bus.req_a[DATA_W-1:0];
            alu_b_r    <= sel ? bus.req_b[2*DATA_W-1:DATA_W] : bus.req_b[DATA_W-1:0];
            alu_ctrl_r <= sel ? bus.req_op[2*CTRL_W-1:CTRL_W] : bus.req_op[CTRL_W-1:0];
          end
        end
        EXEC: begin
          rsp_result_r <= bus.alu_result;
          rsp_zero_r   <= bus.alu_zero;
          rsp_err_r    <= ~legal_op;
        end
        RESP: begin
          if (bus.rsp_ready[grant]) begin
            last_grant <= grant;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.rsp_valid  = rsp_valid_c;
  assign bus.alu_a      = alu_a_r;
  assign bus.alu_b      = alu_b_r;
  assign bus.alu_ctrl   = alu_ctrl_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_zero   = rsp_zero_r;
  assign bus.rsp_err    = rsp_err_r;
  assign bus.busy       = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_share_arbiter : directed scoreboard bench for the shared-ALU arbiter
// Rev 1.0
// ============================================================================
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int CW = 4;

  typedef struct packed {
    logic [1:0]  who;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_share_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  alu_share_arbiter #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // External ALU stand-in; unknown codes yield 0.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b1100: return ~(a | b);
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_ctrl);
  assign bus.alu_zero   = (bus.alu_result == 32'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    bus.req_a[i*DW +: DW]  = a;
    bus.req_b[i*DW +: DW]  = b;
    bus.req_op[i*CW +: CW] = op;
    bus.req_valid[i]       = 1'b1;
  endtask

  // Called at a negedge; returns 1 time unit after the accepting posedge.
  task automatic handshake(input exp_t e);
    int n = 0;
    #1;
    while (bus.req_ready == 2'b00 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("ready_wait", 32'(n < 10), 32'd1);
    chk("req_ready", 32'(bus.req_ready), 32'(e.who));
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic collect(input int hold);
    int   n = 0;
    exp_t e;
    while (bus.rsp_valid == 2'b00 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_wait", 32'(n < 10), 32'd1);
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(e.who));
    chk("rsp_result", bus.rsp_result, e.res);
    chk("rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'(e.who));
      chk("hold_rsp_result", bus.rsp_result, e.res);
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = bus.rsp_ready | e.who;
    @(posedge clk);
    #1;
    bus.rsp_ready = 2'b00;
    @(negedge clk);
    chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic single(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [31:0] res,
                        input logic zero, input logic err);
    logic [1:0] oh;
    oh = (i == 0) ? 2'b01 : 2'b10;
    set_req(i, a, b, op);
    handshake('{oh, res, zero, err});
    bus.req_valid[i] = 1'b0;
    @(negedge clk);
    chk("lat_exec_valid", 32'(bus.rsp_valid), 32'd0);
    chk("lat_exec_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("lat_resp_valid", 32'(bus.rsp_valid), 32'(oh));
    collect(0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Lone ADD, then exercise zero flag and move last grant to requester 1.
    single(0, 32'd5, 32'd3, 4'b0010, 32'd8, 1'b0, 1'b0);
    chk("alu_a_hold", bus.alu_a, 32'd5);
    single(1, 32'd7, 32'd7, 4'b0110, 32'd0, 1'b1, 1'b0);

    // Both requesting continuously: strict alternation starting with 0.
    set_req(0, 32'd9, 32'd4, 4'b0110);
    set_req(1, 32'h0000_00F0, 32'h0000_000F, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) handshake('{2'b01, 32'd5, 1'b0, 1'b0});
      else            handshake('{2'b10, 32'h0000_00FF, 1'b0, 1'b0});
      @(negedge clk);
      @(negedge clk);
      collect(0);
    end
    bus.req_valid = 2'b00;

    single(0, 32'd2, 32'd3, 4'b0111, 32'd1, 1'b0, 1'b0);

    // Stalled response: data held, new request and foreign rsp_ready ignored.
    set_req(1, 32'h0000_FF00, 32'h0000_0FF0, 4'b0000);
    handshake('{2'b10, 32'h0000_0F00, 1'b0, 1'b0});
    bus.req_valid[1] = 1'b0;
    set_req(0, 32'd1, 32'd2, 4'b0001);
    bus.rsp_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    collect(5);
    handshake('{2'b01, 32'd3, 1'b0, 1'b0});
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    collect(0);

    // Illegal code, then a legal one clears the error flag.
    single(0, 32'h1234, 32'h10, 4'b1111, 32'd0, 1'b1, 1'b1);
    single(0, 32'h10, 32'h1, 4'b0110, 32'h0000_000F, 1'b0, 1'b0);

    // Reset mid-EXEC drops the op and restores requester-0 priority.
    set_req(0, 32'd1, 32'd1, 4'b0010);
    set_req(1, 32'hAAAA, 32'h00FF, 4'b0000);
    #1;
    chk("pre_rst_grant", 32'(bus.req_ready), 32'd2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("arst_alu_a", bus.alu_a, 32'd0);
    chk("arst_alu_b", bus.alu_b, 32'd0);
    chk("arst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    chk("arst_rsp_result", bus.rsp_result, 32'd0);
    chk("arst_rsp_flags", 32'({bus.rsp_zero, bus.rsp_err}), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b1;
    handshake('{2'b01, 32'd2, 1'b0, 1'b0});
    bus.req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    collect(0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
